// File: rtl/lif_out_neuron_p.sv
// Leaky integrate-and-fire output neuron with lateral inhibition, refractory period and learning gain.
// Optional membrane leak toward V_REST is enabled by defining LIF_LEAK_EN.
module lif_out_neuron_p #(
    parameter int N_IN       = 25,
    parameter int VW         = 12,
    parameter int V_REST     = 400,
    parameter int V_TH       = 720,
    parameter int V_FLOOR    = 80,
    parameter int INHIB_STEP = 75,
    parameter int SELF_STEP  = 5,
    parameter int PERIOD     = 672,
    parameter int HOLD_START = 332,
    parameter int REFRACT    = 4,
    parameter int GAIN_MAX   = 32,
    parameter int LEAK_DIV   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          learn,
    input  logic                          inhibition,
    input  logic [N_IN-1:0]               syn_up,
    input  logic [N_IN-1:0]               syn_down,
    output logic                          spike,
    output logic                          out_inhi,
    output logic                          post,
    output logic [VW-1:0]                 vmem,
    output logic [$clog2(GAIN_MAX):0]     gain
);

    localparam int GW       = $clog2(GAIN_MAX) + 1;
    localparam int CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int RW       = (REFRACT > 1) ? $clog2(REFRACT) : 1;
    localparam int PW       = $clog2(N_IN + 1);
    localparam int TW       = VW + 8;
    localparam int SW       = VW + 9;
    localparam int REF_LOAD = (REFRACT > 0) ? REFRACT - 1 : 0;

    localparam logic [VW-1:0]        V_REST_V  = VW'(V_REST);
    localparam logic [VW-1:0]        V_TH_V    = VW'(V_TH);
    localparam logic [VW-1:0]        V_FLOOR_V = VW'(V_FLOOR);
    localparam logic [CW-1:0]        CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [CW-1:0]        CNT_PRE   = CW'(PERIOD - 2);
    localparam logic [CW-1:0]        CNT_HOLD  = CW'(HOLD_START);
    localparam logic [GW-1:0]        GAIN_CAP  = GW'(GAIN_MAX);
    localparam logic signed [SW-1:0] INHIB_S   = SW'(INHIB_STEP);
    localparam logic signed [SW-1:0] SELF_S    = SW'(SELF_STEP);
    localparam logic signed [SW-1:0] VMAX_S    = SW'((1 << VW) - 1);

    typedef enum logic [1:0] {
        INTEGRATE  = 2'd0,
        FIRE       = 2'd1,
        REFRACTORY = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [RW-1:0]       ref_cnt;
    logic                learn_d;
    logic                learn_fall;
    logic                syn_any;
    logic [PW-1:0]       pop_up;
    logic [PW-1:0]       pop_down;
    logic signed [PW:0]  pop_diff;
    logic signed [TW-1:0] term;
    logic signed [SW-1:0] vmem_s;
    logic [VW-1:0]       vmem_nxt;

    function automatic logic [PW-1:0] popcount(input logic [N_IN-1:0] bits);
        logic [PW-1:0] sum;
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = sum + PW'(bits[k]);
        end
        return sum;
    endfunction

    function automatic logic [VW-1:0] sat_vmem(input logic signed [SW-1:0] x);
        if (x < 0) begin
            return '0;
        end else if (x > VMAX_S) begin
            return VMAX_S[VW-1:0];
        end
        return x[VW-1:0];
    endfunction

    function automatic logic [GW-1:0] gain_double(input logic [GW-1:0] g);
        logic [GW:0] d;
        d = {g, 1'b0};
        if (d > {1'b0, GAIN_CAP}) begin
            return GAIN_CAP;
        end
        return d[GW-1:0];
    endfunction

    assign learn_fall = learn_d & ~learn;
    assign syn_any    = (|syn_up) | (|syn_down);
    assign pop_up     = popcount(syn_up);
    assign pop_down   = popcount(syn_down);
    assign pop_diff   = $signed({1'b0, pop_up}) - $signed({1'b0, pop_down});
    assign term       = TW'($signed({1'b0, gain})) * TW'(pop_diff);
    assign vmem_s     = $signed({9'b0, vmem});

`ifdef LIF_LEAK_EN
    localparam int LDW = (LEAK_DIV > 1) ? $clog2(LEAK_DIV) : 1;

    logic [LDW-1:0] leak_cnt;
    logic           leak_tick;

    function automatic logic [VW-1:0] leak_toward_rest(input logic [VW-1:0] v);
        if (v > V_REST_V) begin
            return v - VW'(1);
        end else if (v < V_REST_V) begin
            return v + VW'(1);
        end
        return v;
    endfunction

    assign leak_tick = (leak_cnt == LDW'(LEAK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leak_cnt <= '0;
        end else if (leak_tick) begin
            leak_cnt <= '0;
        end else begin
            leak_cnt <= leak_cnt + LDW'(1);
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            INTEGRATE: begin
                if (vmem >= V_TH_V && !inhibition) begin
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                if (REFRACT > 0) begin
                    state_nxt = REFRACTORY;
                end else begin
                    state_nxt = INTEGRATE;
                end
            end
            REFRACTORY: begin
                if (ref_cnt == '0) begin
                    state_nxt = INTEGRATE;
                end
            end
            default: state_nxt = INTEGRATE;
        endcase
        if (learn_fall) begin
            state_nxt = INTEGRATE;
        end
    end

    // Membrane update, highest priority first; inhibition is applied even while refractory.
    always_comb begin
        vmem_nxt = vmem;
        if (state == FIRE) begin
            vmem_nxt = V_REST_V;
        end else if (inhibition) begin
            vmem_nxt = sat_vmem(vmem_s - (out_inhi ? SELF_S : INHIB_S));
        end else if (vmem < V_FLOOR_V || cnt == CNT_LAST || learn_fall) begin
            vmem_nxt = V_REST_V;
        end else if (!learn && cnt >= CNT_HOLD) begin
            vmem_nxt = vmem;
        end else if (state == REFRACTORY) begin
            vmem_nxt = vmem;
        end else if (syn_any) begin
            vmem_nxt = sat_vmem(vmem_s + SW'(term));
`ifdef LIF_LEAK_EN
        end else if (leak_tick) begin
            vmem_nxt = leak_toward_rest(vmem);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INTEGRATE;
            vmem     <= V_REST_V;
            gain     <= GW'(1);
            cnt      <= '0;
            learn_d  <= 1'b0;
            ref_cnt  <= '0;
            spike    <= 1'b0;
            out_inhi <= 1'b0;
            post     <= 1'b0;
        end else begin
            state    <= state_nxt;
            vmem     <= vmem_nxt;
            learn_d  <= learn;
            cnt      <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            // Output flags decode the next state so they line up with the FIRE cycle itself.
            spike    <= (state_nxt == FIRE);
            out_inhi <= (state_nxt == FIRE);
            post     <= learn && ((state == FIRE) || (cnt == CNT_PRE && gain > GW'(1)));
            if (post && gain < GAIN_CAP) begin
                gain <= gain_double(gain);
            end
            if (state == FIRE) begin
                ref_cnt <= RW'(REF_LOAD);
            end else if (state == REFRACTORY && ref_cnt != '0) begin
                ref_cnt <= ref_cnt - RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lif_out_neuron_p.sv
// Directed scoreboard testbench for lif_out_neuron_p (default build, leak disabled).
module tb_lif_out_neuron_p;

    localparam int N_IN   = 25;
    localparam int VW     = 12;
    localparam int GW     = 6;
    localparam int PERIOD = 672;

    logic              clk;
    logic              rst_n;
    logic              learn;
    logic              inhibition;
    logic [N_IN-1:0]   syn_up;
    logic [N_IN-1:0]   syn_down;
    logic              spike;
    logic              out_inhi;
    logic              post;
    logic [VW-1:0]     vmem;
    logic [GW-1:0]     gain;

    typedef struct {
        string         tag;
        logic [VW-1:0] v;
        logic          s;
        logic          i;
        logic          p;
        logic [GW-1:0] g;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;
    int   mcnt;

    lif_out_neuron_p dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .learn      (learn),
        .inhibition (inhibition),
        .syn_up     (syn_up),
        .syn_down   (syn_down),
        .spike      (spike),
        .out_inhi   (out_inhi),
        .post       (post),
        .vmem       (vmem),
        .gain       (gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference window counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else        mcnt <= (mcnt == PERIOD - 1) ? 0 : mcnt + 1;
    end

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, req);
        end
    endtask

    task automatic push(input string tag, input int v, input bit s, input bit i, input bit p, input int g);
        exp_t e;
        e.tag = tag;
        e.v   = VW'(v);
        e.s   = s;
        e.i   = i;
        e.p   = p;
        e.g   = GW'(g);
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            cmp("scoreboard", "empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        cmp(e.tag, "vmem",     32'(vmem),     32'(e.v));
        cmp(e.tag, "spike",    32'(spike),    32'(e.s));
        cmp(e.tag, "out_inhi", 32'(out_inhi), 32'(e.i));
        cmp(e.tag, "post",     32'(post),     32'(e.p));
        cmp(e.tag, "gain",     32'(gain),     32'(e.g));
    endtask

    // Expectation for the outputs after the next rising edge.
    task automatic step(input string tag, input int v, input bit s, input bit i, input bit p, input int g);
        push(tag, v, s, i, p, g);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input string tag, input int v, input bit s, input bit i, input bit p, input int g);
        push(tag, v, s, i, p, g);
        pop_check();
    endtask

    initial begin
        int guard;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        learn      = 1'b1;
        inhibition = 1'b0;
        syn_up     = '0;
        syn_down   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_now("in_reset", 400, 0, 0, 0, 1);
        rst_n = 1'b1;
        check_now("reset_release", 400, 0, 0, 0, 1);

        // Lateral inhibition from rest, then climb back with all synapses
        inhibition = 1'b1;
        step("inhib_pulse", 325, 0, 0, 0, 1);
        inhibition = 1'b0;
        syn_up = '1;
        for (int k = 1; k <= 3; k++) step("climb_back", 325 + 25 * k, 0, 0, 0, 1);

        // Depress down to 100, one more full depression, then floor restore
        syn_up   = '0;
        syn_down = '1;
        for (int k = 1; k <= 12; k++) step("depress", 400 - 25 * k, 0, 0, 0, 1);
        step("below_floor", 75, 0, 0, 0, 1);
        syn_down = '0;
        step("floor_restore", 400, 0, 0, 0, 1);

        // Raise to 600, then a falling edge on learn restores rest
        syn_up = '1;
        for (int k = 1; k <= 8; k++) step("raise", 400 + 25 * k, 0, 0, 0, 1);
        syn_up = '0;
        learn  = 1'b0;
        step("learn_fall", 400, 0, 0, 0, 1);
        learn  = 1'b1;

        // Single-synapse ramp; inhibition at threshold blocks the fire
        syn_up[0] = 1'b1;
        for (int k = 1; k <= 320; k++) step("ramp1", 400 + k, 0, 0, 0, 1);
        inhibition = 1'b1;
        step("inhib_at_th", 645, 0, 0, 0, 1);
        inhibition = 1'b0;
        for (int k = 1; k <= 75; k++) step("ramp1b", 645 + k, 0, 0, 0, 1);
        step("fire1", 721, 1, 1, 0, 1);
        step("rest1", 400, 0, 0, 1, 1);
        step("refr1_gain", 400, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) step("refr1_hold", 400, 0, 0, 0, 2);
        for (int k = 1; k <= 160; k++) step("ramp2", 400 + 2 * k, 0, 0, 0, 2);
        step("fire2", 722, 1, 1, 0, 2);
        inhibition = 1'b1;
        step("inhib_in_fire", 400, 0, 0, 1, 2);
        step("inhib_in_refr", 325, 0, 0, 0, 4);
        inhibition = 1'b0;
        for (int k = 0; k < 3; k++) step("refr2_hold", 325, 0, 0, 0, 4);
        syn_up = '0;

        // Hold window with learn low, then end-of-window restore and wrap
        learn  = 1'b0;
        syn_up = '1;
        step("fall_in_window", 400, 0, 0, 0, 4);
        inhibition = 1'b1;
        step("inhib_in_window", 325, 0, 0, 0, 4);
        inhibition = 1'b0;
        guard = 0;
        while (mcnt != PERIOD - 1 && guard < 2 * PERIOD) begin
            step("window_hold", 325, 0, 0, 0, 4);
            guard++;
        end
        cmp("window_hold", "reached_end", 32'(mcnt), 32'(PERIOD - 1));
        step("window_end", 400, 0, 0, 0, 4);
        step("after_wrap", 500, 0, 0, 0, 4);

        // Learning window: post pulse near the window end doubles gain
        learn  = 1'b1;
        syn_up = '0;
        guard  = 0;
        while (mcnt != PERIOD - 1 && guard < 2 * PERIOD) begin
            step("window_post", 500, 0, 0, (mcnt == PERIOD - 2), 4);
            guard++;
        end
        cmp("window_post", "reached_end", 32'(mcnt), 32'(PERIOD - 1));
        step("post_gain", 400, 0, 0, 0, 8);

        // Fire at gain 8, then asynchronous reset in the middle of the FIRE cycle
        syn_up = '1;
        step("g8_int1", 600, 0, 0, 0, 8);
        step("g8_int2", 800, 0, 0, 0, 8);
        step("fire3", 1000, 1, 1, 0, 8);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 400, 0, 0, 0, 1);
        syn_up = '0;
        #1;
        rst_n = 1'b1;
        step("post_reset", 400, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_out_neuron_p.md
LIF_OUT_NEURON_P -- requirements
Module: lif_out_neuron_p

Interface
REQ-001 Parameters (name, default, meaning): N_IN 25 synapse channels; VW 12 membrane width; V_REST 400 resting potential; V_TH 720 fire threshold; V_FLOOR 80 restore floor; INHIB_STEP 75 lateral-inhibition decrement; SELF_STEP 5 decrement when inhibited during own out_inhi; PERIOD 672 window length; HOLD_START 332 window hold start; REFRACT 4 refractory cycles; GAIN_MAX 32 gain ceiling; LEAK_DIV 16 leak divider.
REQ-002 Ports (name, direction, width, meaning): clk in 1 clock; rst_n in 1 async active-low reset; learn in 1 learning mode; inhibition in 1 lateral inhibition; syn_up in N_IN potentiating synapse events; syn_down in N_IN depressing synapse events; spike out 1 output spike; out_inhi out 1 lateral-inhibition request; post out 1 postsynaptic learning pulse; vmem out VW membrane potential; gain out $clog2(GAIN_MAX)+1 synaptic gain.
REQ-003 Reset rst_n, asynchronous, active-low; clock clk; all state updates on posedge clk.

Function
REQ-004 Window counter cnt counts 0..PERIOD-1 continuously; wraps to 0.
REQ-005 learn_fall = registered learn (learn_d) AND NOT learn, evaluated in the current cycle.
REQ-006 FSM states INTEGRATE, FIRE, REFRACTORY.
REQ-007 INTEGRATE->FIRE when vmem >= V_TH and inhibition=0; FIRE->REFRACTORY (REFRACT>0) else INTEGRATE; REFRACTORY->INTEGRATE after exactly REFRACT cycles; learn_fall forces INTEGRATE from any state.
REQ-008 Integration term = gain*(popcount(syn_up) - popcount(syn_down)), computed signed, VW+8 bits.
REQ-009 vmem next-value priority, highest first: (a) state FIRE -> V_REST; (b) inhibition -> vmem - (out_inhi ? SELF_STEP : INHIB_STEP), floor 0; (c) vmem < V_FLOOR, cnt==PERIOD-1, or learn_fall -> V_REST; (d) learn=0 and cnt >= HOLD_START -> hold; (e) REFRACTORY -> hold; (f) vmem + integration term, saturated to [0, 2^VW-1]; (g) leak per REQ-017/018.
REQ-010 spike = 1 exactly in cycles where state is FIRE (registered decode, one cycle per fire).
REQ-011 out_inhi registered; equals 1 in FIRE cycle only.
REQ-012 post registered; 1 in cycle after FIRE if learn=1, or when cnt==PERIOD-2 with gain>1 and learn=1; else 0.
REQ-013 gain doubles on any cycle with post=1 while gain < GAIN_MAX; never exceeds GAIN_MAX; unchanged by learn_fall.
REQ-014 Simultaneous inhibition and threshold crossing: inhibition wins; no fire that cycle.
REQ-015 Refractory count restarts on each FIRE; syn inputs ignored in REFRACTORY, inhibition still applied.

Reset
REQ-016 On rst_n=0: vmem=V_REST, gain=1, cnt=0, state INTEGRATE, learn_d=0, refractory count 0, spike=out_inhi=post=0; takes effect immediately regardless of clk, including mid-FIRE or mid-REFRACTORY.

Configuration
REQ-017 Macro LIF_LEAK_EN defined: leak divider counts LEAK_DIV cycles; on terminal count, when rule (g) reached and no syn_up/syn_down bit set, vmem moves 1 toward V_REST (unchanged if equal).
REQ-018 LIF_LEAK_EN undefined: no leak logic, rule (g) holds vmem; all other behaviour identical.

Verification
REQ-019 Reset released -> vmem=400, gain=1, spike/out_inhi/post=0.
REQ-020 learn=1, syn_up=1 bit constantly from vmem=400 -> vmem +1/cycle, spike when 720 reached, vmem=400 next cycle, post one cycle later, gain=2; next spike ~160 cycles + 4 refractory later.
REQ-021 vmem=400, single inhibition pulse, out_inhi=0 -> vmem=325 next cycle; with out_inhi=1 -> vmem=395.
REQ-022 vmem=600, learn 1->0 -> vmem=400 and state INTEGRATE next cycle.
REQ-023 vmem=100, gain=1, all 25 syn_down bits -> vmem=75, next cycle restored to 400.
REQ-024 learn=0, cnt>=332, syn_up active -> vmem held; at cnt=671 -> vmem=400, cnt=0.
